// File: rtl/rob_retire_if.sv
// rob_retire_if
//   Bundles the reorder-buffer dispatch, completion, retire, free-list,
//   store-commit and status signals into one interface.
//   slave  : the ROB controller side (consumes dispatch/completion/st_ready).
//   master : the core/testbench side (drives dispatch/completion/st_ready).
//   Signals:
//     disp_valid/disp_p_rd/disp_p_old_rd/disp_is_sw  dispatch of up to 2 instrs
//     disp_ready/disp_rob_idx                        dispatch acceptance + slots
//     cmp_valid/cmp_rob_idx/cmp_data                 3 functional-unit results
//     ret_valid/ret_p_rd/ret_data                    in-order commit strobes
//     free_valid/free_preg                           old pregs released
//     st_valid/st_data/st_rob_idx/st_ready           store commit handshake
//     rob_count/rob_empty                            occupancy
interface rob_retire_if #(
    parameter int IDX_W  = 6,
    parameter int PREG_W = 6,
    parameter int DATA_W = 32
);
    logic [1:0]              disp_valid;
    logic [1:0][PREG_W-1:0]  disp_p_rd;
    logic [1:0][PREG_W-1:0]  disp_p_old_rd;
    logic [1:0]              disp_is_sw;
    logic                    disp_ready;
    logic [1:0][IDX_W-1:0]   disp_rob_idx;

    logic [2:0]              cmp_valid;
    logic [2:0][IDX_W-1:0]   cmp_rob_idx;
    logic [2:0][DATA_W-1:0]  cmp_data;

    logic [1:0]              ret_valid;
    logic [1:0][PREG_W-1:0]  ret_p_rd;
    logic [1:0][DATA_W-1:0]  ret_data;
    logic [1:0]              free_valid;
    logic [1:0][PREG_W-1:0]  free_preg;

    logic                    st_valid;
    logic [DATA_W-1:0]       st_data;
    logic [IDX_W-1:0]        st_rob_idx;
    logic                    st_ready;

    logic [IDX_W:0]          rob_count;
    logic                    rob_empty;

    modport slave (
        input  disp_valid, disp_p_rd, disp_p_old_rd, disp_is_sw,
        input  cmp_valid, cmp_rob_idx, cmp_data,
        input  st_ready,
        output disp_ready, disp_rob_idx,
        output ret_valid, ret_p_rd, ret_data, free_valid, free_preg,
        output st_valid, st_data, st_rob_idx,
        output rob_count, rob_empty
    );

    modport master (
        output disp_valid, disp_p_rd, disp_p_old_rd, disp_is_sw,
        output cmp_valid, cmp_rob_idx, cmp_data,
        output st_ready,
        input  disp_ready, disp_rob_idx,
        input  ret_valid, ret_p_rd, ret_data, free_valid, free_preg,
        input  st_valid, st_data, st_rob_idx,
        input  rob_count, rob_empty
    );
endinterface

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl
//   Reorder-buffer controller. Allocates up to two entries per cycle at the
//   tail, records results from three functional units, and retires completed
//   entries in program order (up to two per cycle) from the head. Stores at
//   the head are committed one at a time through a valid/ready handshake.
//   Ports:
//     clk  core clock, all state on posedge
//     rst  synchronous active-high reset
//     rob  rob_retire_if.slave (dispatch, completion, retire, free, store, status)
module rob_retire_ctrl #(
    parameter int ROB_DEPTH = 64,
    parameter int IDX_W     = 6,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32
) (
    input logic         clk,
    input logic         rst,
    rob_retire_if.slave rob
);
    typedef enum logic {RUN = 1'b0, STORE = 1'b1} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE   = 1;
    localparam logic [IDX_W:0]   READY_MAX = (IDX_W+1)'(ROB_DEPTH - 2);

    state_t state, state_next;

    logic [IDX_W-1:0] head, tail, head_p1, tail_p1;
    logic [IDX_W:0]   count;

    logic [ROB_DEPTH-1:0] used, completed, is_sw_mem;
    logic [PREG_W-1:0]    p_rd_mem  [ROB_DEPTH];
    logic [PREG_W-1:0]    p_old_mem [ROB_DEPTH];
    logic [DATA_W-1:0]    data_mem  [ROB_DEPTH];

    logic       take0, take1;
    logic [1:0] ndisp, nret;
    logic       head_ok, next_ok;
    logic       ret0, ret1, st_retire;

    assign head_p1 = head + IDX_ONE;
    assign tail_p1 = tail + IDX_ONE;

    // Readiness looks only at the current count, so a slot freed this cycle
    // is never reused in the same cycle.
    assign rob.disp_ready   = (count <= READY_MAX);
    assign rob.disp_rob_idx = {tail_p1, tail};
    assign rob.rob_count    = count;
    assign rob.rob_empty    = (count == '0);

    // Slot 1 is only taken together with slot 0.
    assign take0 = rob.disp_ready && rob.disp_valid[0];
    assign take1 = take0 && rob.disp_valid[1];
    assign ndisp = {1'b0, take0} + {1'b0, take1};
    assign nret  = {1'b0, ret0 | st_retire} + {1'b0, ret1};

    assign head_ok = used[head] && completed[head];
    assign next_ok = used[head_p1] && completed[head_p1];

    // Retire selection. Stores never retire through the normal path; head+1
    // only goes along with head, and never if it is itself a store.
    always_comb begin
        ret0      = 1'b0;
        ret1      = 1'b0;
        st_retire = 1'b0;
        if (state == RUN) begin
            if (head_ok && !is_sw_mem[head]) begin
                ret0 = 1'b1;
                ret1 = next_ok && !is_sw_mem[head_p1];
            end
        end else begin
            st_retire = rob.st_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (head_ok && is_sw_mem[head]) state_next = STORE;
            STORE:   if (rob.st_ready)               state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // The head entry cannot move while in STORE, so data/index stay stable.
    always_comb begin
        rob.st_valid   = 1'b0;
        rob.st_data    = '0;
        rob.st_rob_idx = '0;
        if (state == STORE) begin
            rob.st_valid   = 1'b1;
            rob.st_data    = data_mem[head];
            rob.st_rob_idx = head;
        end
    end

    // Control state and registered retire/free strobes. Within the cycle the
    // retire clears are written last so they win over a stray completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            used           <= '0;
            completed      <= '0;
            rob.ret_valid  <= '0;
            rob.ret_p_rd   <= '0;
            rob.ret_data   <= '0;
            rob.free_valid <= '0;
            rob.free_preg  <= '0;
        end else begin
            // FU loop runs high to low so the lowest FU number wins.
            for (int f = 2; f >= 0; f--) begin
                if (rob.cmp_valid[f] && used[rob.cmp_rob_idx[f]]) begin
                    completed[rob.cmp_rob_idx[f]] <= 1'b1;
                end
            end
            if (take0) begin
                used[tail]      <= 1'b1;
                completed[tail] <= 1'b0;
            end
            if (take1) begin
                used[tail_p1]      <= 1'b1;
                completed[tail_p1] <= 1'b0;
            end
            if (ret0 || st_retire) begin
                used[head]      <= 1'b0;
                completed[head] <= 1'b0;
            end
            if (ret1) begin
                used[head_p1]      <= 1'b0;
                completed[head_p1] <= 1'b0;
            end

            head  <= head + IDX_W'(nret);
            tail  <= tail + IDX_W'(ndisp);
            count <= count + (IDX_W+1)'(ndisp) - (IDX_W+1)'(nret);

            rob.ret_valid   <= {ret1, ret0};
            rob.ret_p_rd[0] <= ret0 ? p_rd_mem[head]    : '0;
            rob.ret_p_rd[1] <= ret1 ? p_rd_mem[head_p1] : '0;
            rob.ret_data[0] <= ret0 ? data_mem[head]    : '0;
            rob.ret_data[1] <= ret1 ? data_mem[head_p1] : '0;

            rob.free_valid[0] <= (ret0 || st_retire) && (p_old_mem[head] != '0);
            rob.free_valid[1] <= ret1 && (p_old_mem[head_p1] != '0);
            rob.free_preg[0]  <= (ret0 || st_retire) ? p_old_mem[head] : '0;
            rob.free_preg[1]  <= ret1 ? p_old_mem[head_p1] : '0;
        end
    end

    // Payload storage; validity is tracked by used/completed, so no reset.
    always_ff @(posedge clk) begin
        for (int f = 2; f >= 0; f--) begin
            if (rob.cmp_valid[f] && used[rob.cmp_rob_idx[f]]) begin
                data_mem[rob.cmp_rob_idx[f]] <= rob.cmp_data[f];
            end
        end
        if (take0) begin
            p_rd_mem[tail]  <= rob.disp_p_rd[0];
            p_old_mem[tail] <= rob.disp_p_old_rd[0];
            is_sw_mem[tail] <= rob.disp_is_sw[0];
        end
        if (take1) begin
            p_rd_mem[tail_p1]  <= rob.disp_p_rd[1];
            p_old_mem[tail_p1] <= rob.disp_p_old_rd[1];
            is_sw_mem[tail_p1] <= rob.disp_is_sw[1];
        end
    end
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// tb_rob_retire_ctrl
//   Directed self-checking bench for rob_retire_ctrl: reset state, paired
//   retire, store commit handshake, full/wrap, completion priority and
//   mid-operation reset.
module tb_rob_retire_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    rob_retire_if bus ();

    rob_retire_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rob (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.disp_valid    = '0;
        bus.disp_p_rd     = '0;
        bus.disp_p_old_rd = '0;
        bus.disp_is_sw    = '0;
        bus.cmp_valid     = '0;
        bus.cmp_rob_idx   = '0;
        bus.cmp_data      = '0;
        bus.st_ready      = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] dv, input logic [5:0] rd0, input logic [5:0] old0,
                                 input logic [5:0] rd1, input logic [5:0] old1, input logic [1:0] sw);
        bus.disp_valid       = dv;
        bus.disp_p_rd[0]     = rd0;
        bus.disp_p_old_rd[0] = old0;
        bus.disp_p_rd[1]     = rd1;
        bus.disp_p_old_rd[1] = old1;
        bus.disp_is_sw       = sw;
    endtask

    task automatic setCmp(input int fu, input logic [5:0] idx, input logic [31:0] data);
        bus.cmp_valid[fu]   = 1'b1;
        bus.cmp_rob_idx[fu] = idx;
        bus.cmp_data[fu]    = data;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();

        // 1: reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_ret_valid",  64'(bus.ret_valid), 64'd0);
        checkOutput("rst_free_valid", 64'(bus.free_valid), 64'd0);
        checkOutput("rst_st_valid",   64'(bus.st_valid), 64'd0);
        checkOutput("rst_st_data",    64'(bus.st_data), 64'd0);
        checkOutput("rst_count",      64'(bus.rob_count), 64'd0);
        checkOutput("rst_empty",      64'(bus.rob_empty), 64'd1);
        checkOutput("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        checkOutput("rst_disp_idx",   64'(bus.disp_rob_idx), 64'h040);
        rst = 1'b0;

        // 2: two ALU ops completing out of order, retiring together
        applyStimulus(2'b11, 6'd5, 6'd3, 6'd6, 6'd4, 2'b00);
        tick();
        checkOutput("t2_count", 64'(bus.rob_count), 64'd2);
        checkOutput("t2_disp_idx", 64'(bus.disp_rob_idx), 64'h0C2);
        idleInputs();
        setCmp(0, 6'd1, 32'hAA);
        tick();
        checkOutput("t2_no_ret_a", 64'(bus.ret_valid), 64'd0);
        idleInputs();
        setCmp(1, 6'd0, 32'hBB);
        tick();
        checkOutput("t2_no_ret_b", 64'(bus.ret_valid), 64'd0);
        idleInputs();
        tick();
        checkOutput("t2_ret_valid",  64'(bus.ret_valid), 64'd3);
        checkOutput("t2_ret_p_rd",   64'(bus.ret_p_rd), 64'h185);
        checkOutput("t2_ret_data",   64'(bus.ret_data), 64'h0000_00AA_0000_00BB);
        checkOutput("t2_free_valid", 64'(bus.free_valid), 64'd3);
        checkOutput("t2_free_preg",  64'(bus.free_preg), 64'h103);
        checkOutput("t2_empty",      64'(bus.rob_empty), 64'd1);
        tick();
        checkOutput("t2_ret_one_cycle", 64'(bus.ret_valid), 64'd0);

        // 3: store commit with st_ready held low for three cycles
        doReset();
        applyStimulus(2'b01, 6'd9, 6'd0, 6'd0, 6'd0, 2'b01);
        tick();
        idleInputs();
        setCmp(2, 6'd0, 32'h1234_5678);
        tick();
        checkOutput("t3_st_not_yet", 64'(bus.st_valid), 64'd0);
        idleInputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("t3_st_valid_wait", 64'(bus.st_valid), 64'd1);
            checkOutput("t3_st_data",       64'(bus.st_data), 64'h1234_5678);
            checkOutput("t3_st_idx",        64'(bus.st_rob_idx), 64'd0);
            checkOutput("t3_no_ret",        64'(bus.ret_valid), 64'd0);
        end
        tick();
        bus.st_ready = 1'b1;
        checkOutput("t3_st_valid_last", 64'(bus.st_valid), 64'd1);
        tick();
        bus.st_ready = 1'b0;
        checkOutput("t3_st_done",   64'(bus.st_valid), 64'd0);
        checkOutput("t3_no_free",   64'(bus.free_valid), 64'd0);
        checkOutput("t3_no_ret2",   64'(bus.ret_valid), 64'd0);
        checkOutput("t3_count",     64'(bus.rob_count), 64'd0);
        checkOutput("t3_disp_idx",  64'(bus.disp_rob_idx), 64'h081);

        // 4: fill to 63, stall, retire two, wrap the tail
        doReset();
        for (int k = 0; k < 31; k++) begin
            applyStimulus(2'b11, 6'(2 * k), 6'd10, 6'(2 * k + 1), 6'd11, 2'b00);
            tick();
        end
        checkOutput("t4_count62", 64'(bus.rob_count), 64'd62);
        checkOutput("t4_ready62", 64'(bus.disp_ready), 64'd1);
        applyStimulus(2'b01, 6'd62, 6'd10, 6'd0, 6'd0, 2'b00);
        tick();
        checkOutput("t4_count63", 64'(bus.rob_count), 64'd63);
        checkOutput("t4_ready63", 64'(bus.disp_ready), 64'd0);
        applyStimulus(2'b11, 6'd40, 6'd10, 6'd41, 6'd11, 2'b00);
        tick();
        checkOutput("t4_ignored", 64'(bus.rob_count), 64'd63);
        checkOutput("t4_idx_hold", 64'(bus.disp_rob_idx), 64'h03F);
        setCmp(0, 6'd0, 32'h100);
        setCmp(1, 6'd1, 32'h101);
        tick();
        bus.cmp_valid = '0;
        checkOutput("t4_still_full", 64'(bus.rob_count), 64'd63);
        tick();
        checkOutput("t4_ret_valid", 64'(bus.ret_valid), 64'd3);
        checkOutput("t4_ret_p_rd",  64'(bus.ret_p_rd), 64'h040);
        checkOutput("t4_ret_data",  64'(bus.ret_data), 64'h0000_0101_0000_0100);
        checkOutput("t4_free_preg", 64'(bus.free_preg), 64'h2CA);
        checkOutput("t4_count61",   64'(bus.rob_count), 64'd61);
        checkOutput("t4_ready61",   64'(bus.disp_ready), 64'd1);
        checkOutput("t4_wrap_idx",  64'(bus.disp_rob_idx), 64'h03F);
        tick();
        idleInputs();
        checkOutput("t4_count_after", 64'(bus.rob_count), 64'd63);
        checkOutput("t4_tail_wrapped", 64'(bus.disp_rob_idx), 64'h081);

        // 5: FU priority on same index, completion to unused entry ignored
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 6'(2 * k + 32), 6'd0, 6'(2 * k + 33), 6'd0, 2'b00);
            tick();
        end
        idleInputs();
        setCmp(0, 6'd0, 32'h10);
        setCmp(1, 6'd1, 32'h11);
        tick();
        idleInputs();
        setCmp(0, 6'd2, 32'h12);
        setCmp(1, 6'd3, 32'h13);
        tick();
        idleInputs();
        setCmp(0, 6'd4, 32'h14);
        setCmp(1, 6'd5, 32'h15);
        tick();
        idleInputs();
        setCmp(0, 6'd6, 32'h16);
        tick();
        idleInputs();
        setCmp(0, 6'd7, 32'h7700);
        setCmp(2, 6'd7, 32'h22);
        setCmp(1, 6'd20, 32'hDEAD);
        tick();
        idleInputs();
        checkOutput("t5_ret6_valid", 64'(bus.ret_valid), 64'd1);
        checkOutput("t5_ret6_p_rd",  64'(bus.ret_p_rd[0]), 64'd38);
        tick();
        checkOutput("t5_ret7_valid", 64'(bus.ret_valid), 64'd1);
        checkOutput("t5_ret7_p_rd",  64'(bus.ret_p_rd[0]), 64'd39);
        checkOutput("t5_fu0_wins",   64'(bus.ret_data[0]), 64'h7700);
        checkOutput("t5_count",      64'(bus.rob_count), 64'd0);
        tick();
        checkOutput("t5_unused_ignored", 64'(bus.ret_valid), 64'd0);
        checkOutput("t5_empty",          64'(bus.rob_empty), 64'd1);

        // 6: reset while a head store waits in STORE with 10 entries live
        doReset();
        applyStimulus(2'b11, 6'd20, 6'd0, 6'd21, 6'd3, 2'b01);
        tick();
        for (int k = 1; k < 5; k++) begin
            applyStimulus(2'b11, 6'(20 + 2 * k), 6'd1, 6'(21 + 2 * k), 6'd2, 2'b00);
            tick();
        end
        idleInputs();
        setCmp(2, 6'd0, 32'hCAFE);
        tick();
        idleInputs();
        tick();
        checkOutput("t6_in_store",  64'(bus.st_valid), 64'd1);
        checkOutput("t6_st_data",   64'(bus.st_data), 64'hCAFE);
        checkOutput("t6_count10",   64'(bus.rob_count), 64'd10);
        rst = 1'b1;
        tick();
        checkOutput("t6_st_cleared", 64'(bus.st_valid), 64'd0);
        checkOutput("t6_count0",     64'(bus.rob_count), 64'd0);
        checkOutput("t6_no_ret",     64'(bus.ret_valid), 64'd0);
        checkOutput("t6_no_free",    64'(bus.free_valid), 64'd0);
        checkOutput("t6_ptrs",       64'(bus.disp_rob_idx), 64'h040);
        rst = 1'b0;
        tick();
        checkOutput("t6_stays_run",  64'(bus.st_valid), 64'd0);
        checkOutput("t6_empty",      64'(bus.rob_empty), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
